// File: rtl/tx_sched_pkg.sv
// Shared types and helpers for the TDMA transmit slot scheduler.
package tx_sched_pkg;

  localparam int WORD_W    = 32;
  localparam int MAX_SLOTS = 16;

  typedef enum logic [1:0] {IDLE, LOAD, AIR, GUARD} sched_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } next_slot_t;

  // First enabled slot strictly after current, wrapping; current itself is checked last.
  function automatic next_slot_t next_enabled(input logic [MAX_SLOTS-1:0] enable,
                                              input logic [3:0]           current,
                                              input int                   nslots);
    next_slot_t r;
    int         k;
    r = '0;
    for (int i = 1; i <= MAX_SLOTS; i++) begin
      k = (int'(current) + i) % nslots;
      if (i <= nslots && !r.found && enable[k[3:0]]) begin
        r.found = 1'b1;
        r.idx   = k[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/clk1x_tick_gen.sv
// Free-running divider: o_tick is high for the one cycle the count sits at THRESH-1.
module clk1x_tick_gen #(
  parameter int THRESH = 500
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = (THRESH > 1) ? $clog2(THRESH) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(THRESH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/tx_slot_scheduler.sv
// Round-robin TDMA scheduler sharing the transmitter word port among NUM_SLOTS requesters.
// Define SCHED_STATS_EN to add the saturating words_sent / empty_slots counters.
module tx_slot_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NUM_SLOTS         = 5,
  parameter int WORDS_PER_SLOT    = 8,
  parameter int clk1x_freq        = 1000,
  parameter int count1x_threshold = 500000 / clk1x_freq,
  parameter int SLOT_TICKS        = 1740,
  parameter int GUARD_CLKS        = 160
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [NUM_SLOTS-1:0]        slot_enable,
  input  logic [NUM_SLOTS-1:0]        req_valid,
  input  logic [NUM_SLOTS-1:0]        req_last,
  input  logic [NUM_SLOTS*WORD_W-1:0] req_data,
  output logic [NUM_SLOTS-1:0]        req_ready,
  output logic [WORD_W-1:0]           data_buffer,
  output logic                        data_buffer_valid,
  output logic                        tx_flush,
  output logic [3:0]                  active_slot,
  output logic                        slot_start,
  output logic                        frame_start
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]                 words_sent,
  output logic [15:0]                 empty_slots
`endif
);

  localparam int CW = $clog2(WORDS_PER_SLOT + 1);

  sched_state_t      r_state;
  logic [3:0]        r_active;
  logic [CW-1:0]     r_cnt;
  logic [15:0]       r_air;
  logic [15:0]       r_guard;
  logic [WORD_W-1:0] r_data;
  logic              r_dv, r_flush, r_slot_start, r_frame_start;

  logic                 w_tick;
  logic [15:0]          w_en16;
  logic [NUM_SLOTS-1:0] w_sel;
  logic                 w_valid, w_last, w_hs, w_cap, w_room;
  logic [WORD_W-1:0]    w_data;
  next_slot_t           w_first, w_next;

  clk1x_tick_gen #(.THRESH(count1x_threshold)) u_tick (
    .i_clk  (CLOCK_50),
    .i_rst  (reset),
    .o_tick (w_tick)
  );

  always_comb begin
    w_en16                  = '0;
    w_en16[NUM_SLOTS-1:0]   = slot_enable;
    w_sel                   = '0;
    w_valid                 = 1'b0;
    w_last                  = 1'b0;
    w_data                  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_active == 4'(i)) begin
        w_sel[i] = 1'b1;
        w_valid  = req_valid[i];
        w_last   = req_last[i];
        w_data   = req_data[WORD_W*i +: WORD_W];
      end
    end
  end

  // Starting the search from the top index makes slot 0 the first candidate.
  assign w_first   = next_enabled(w_en16, 4'(NUM_SLOTS - 1), NUM_SLOTS);
  assign w_next    = next_enabled(w_en16, r_active, NUM_SLOTS);
  assign w_room    = (r_state == LOAD) && (r_cnt < CW'(WORDS_PER_SLOT));
  assign w_hs      = w_room && w_valid;
  assign w_cap     = (r_cnt == CW'(WORDS_PER_SLOT - 1));
  assign req_ready = w_room ? w_sel : '0;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_active      <= '0;
      r_cnt         <= '0;
      r_air         <= '0;
      r_guard       <= '0;
      r_data        <= '0;
      r_dv          <= 1'b0;
      r_flush       <= 1'b0;
      r_slot_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_dv          <= 1'b0;
      r_flush       <= 1'b0;
      r_slot_start  <= 1'b0;
      r_frame_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_first.found) begin
            r_active      <= w_first.idx;
            r_cnt         <= '0;
            r_slot_start  <= 1'b1;
            r_frame_start <= 1'b1;
            r_state       <= LOAD;
          end
        end
        LOAD: begin
          if (w_hs) begin
            r_data <= w_data;
            r_dv   <= 1'b1;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last || w_cap) begin
              r_air   <= '0;
              r_state <= AIR;
            end
          end else begin
            // Requester not ready: the slot still owns its air time.
            r_air   <= '0;
            r_state <= AIR;
          end
        end
        AIR: begin
          if (w_tick) begin
            if (r_air == 16'(SLOT_TICKS - 1)) begin
              r_guard <= '0;
              r_flush <= 1'b1;
              r_state <= GUARD;
            end else begin
              r_air <= r_air + 16'd1;
            end
          end
        end
        GUARD: begin
          if (r_guard == 16'(GUARD_CLKS - 1)) begin
            if (w_next.found) begin
              r_active      <= w_next.idx;
              r_cnt         <= '0;
              r_slot_start  <= 1'b1;
              r_frame_start <= (w_next.idx <= r_active);
              r_state       <= LOAD;
            end else begin
              r_active <= '0;
              r_state  <= IDLE;
            end
          end else begin
            r_guard <= r_guard + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_buffer       = r_data;
  assign data_buffer_valid = r_dv;
  assign tx_flush          = r_flush;
  assign active_slot       = r_active;
  assign slot_start        = r_slot_start;
  assign frame_start       = r_frame_start;

`ifdef SCHED_STATS_EN
  logic [15:0] r_words, r_empty;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_words <= '0;
      r_empty <= '0;
    end else begin
      if (r_dv && r_words != 16'hFFFF)
        r_words <= r_words + 16'd1;
      if (r_state == LOAD && !w_hs && r_cnt == '0 && r_empty != 16'hFFFF)
        r_empty <= r_empty + 16'd1;
    end
  end

  assign words_sent  = r_words;
  assign empty_slots = r_empty;
`endif

endmodule
